// File: rtl/ps2_scancode_fifo.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame checker, optional E0/F0 prefix folding
// (enable with `define PS2_DECODE_EN) and a first-word-fall-through scancode FIFO.
module ps2_scancode_fifo #(
    parameter int DEPTH      = 8,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 2048,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     nRESET,
    input  logic                     clk_en,
    input  logic                     PS2_CLK,
    input  logic                     PS2_DATA,
    input  logic                     rd_en,
    output logic [9:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         frame_err_cnt,
    output logic [CNT_W-1:0]         timeout_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else if (clk_en) begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DATA;
            dat_s2_q <= dat_s1_q;
        end
    end

    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          strobe;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = filt_cnt_q;
        strobe     = 1'b0;
        if (clk_en) begin
            if (clk_s2_q == filt_clk_q) begin
                filt_cnt_d = '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s2_q;
                filt_cnt_d = '0;
                strobe     = filt_clk_q;   // only the high-to-low transition clocks a bit
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          code_vld_q, code_vld_d;
    logic [7:0]    code_q, code_d;
    logic          frame_err, timeout_hit;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        wd_d        = wd_q;
        code_vld_d  = 1'b0;
        code_d      = code_q;
        frame_err   = 1'b0;
        timeout_hit = 1'b0;
        if (clk_en) begin
            if (state_q == S_IDLE || strobe) begin
                wd_d = '0;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
                wd_d        = '0;
                timeout_hit = 1'b1;
                state_d     = S_IDLE;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end
        if (strobe) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2_q && ^{shift_q, parity_q}) begin
                        code_vld_d = 1'b1;
                        code_d     = shift_q;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wd_q       <= '0;
            code_vld_q <= 1'b0;
            code_q     <= '0;
        end else begin
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            wd_q       <= wd_d;
            code_vld_q <= code_vld_d;
            code_q     <= code_d;
        end
    end

    logic       push;
    logic [9:0] push_data;

`ifdef PS2_DECODE_EN
    logic ext_q, ext_d, brk_q, brk_d;

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        push      = 1'b0;
        push_data = {ext_q, brk_q, code_q};
        if (frame_err || timeout_hit) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (code_vld_q) begin
            if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end
`else
    assign push      = code_vld_q;
    assign push_data = {2'b00, code_q};
`endif

    logic [9:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        pop, wr_en, drop, overflow_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign pop     = rd_en && !empty;
    assign wr_en   = push && (!full || pop);
    assign drop    = push && full && !pop;

    // NOTE: storage is left unreset; the empty flag masks stale contents from rd_data.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    logic [CNT_W-1:0] frame_err_cnt_q, timeout_cnt_q;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            overflow_q      <= 1'b0;
            frame_err_cnt_q <= '0;
            timeout_cnt_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
            if (frame_err && frame_err_cnt_q != '1) frame_err_cnt_q <= frame_err_cnt_q + 1'b1;
            if (timeout_hit && timeout_cnt_q != '1) timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end
    end

    assign overflow      = overflow_q;
    assign frame_err_cnt = frame_err_cnt_q;
    assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Scoreboard bench for ps2_scancode_fifo: framing, parity, prefixes, overflow, timeout, glitch filter.
`timescale 1ns/1ps
module tb_ps2_scancode_fifo;
    localparam int DEPTH      = 8;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 64;
    localparam int CNT_W      = 8;
    localparam int HALF       = 8;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             nRESET = 1'b0;
    logic             clk_en = 1'b0;
    logic             PS2_CLK = 1'b1;
    logic             PS2_DATA = 1'b1;
    logic             rd_en = 1'b0;
    logic             ovf_clr = 1'b0;
    logic [9:0]       rd_data;
    logic             empty, full, overflow;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] frame_err_cnt, timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int en_div   = 64;
    int div_cnt  = 0;

    logic [9:0] sb[$];
    bit         exp_ovf;
    int         exp_ferr = 0;
    int         exp_tout = 0;
`ifdef PS2_DECODE_EN
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
`endif

    ps2_scancode_fifo #(
        .DEPTH(DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .ovf_clr(ovf_clr), .frame_err_cnt(frame_err_cnt),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_cnt >= en_div - 1) begin
            div_cnt = 0;
            clk_en  = 1'b1;
        end else begin
            div_cnt = div_cnt + 1;
            clk_en  = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!clk_en) @(posedge clk);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit do_push, output logic [9:0] val);
`ifdef PS2_DECODE_EN
        do_push = 1'b0;
        val     = '0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            do_push = 1'b1;
            val     = {m_ext, m_brk, b};
            m_ext   = 1'b0;
            m_brk   = 1'b0;
        end
`else
        do_push = 1'b1;
        val     = {2'b00, b};
`endif
    endtask

    task automatic model_clear_prefix();
`ifdef PS2_DECODE_EN
        m_ext = 1'b0;
        m_brk = 1'b0;
`endif
    endtask

    // Drives one 11-bit frame; during the stop bit it watches for the push and can pulse rd_en at clk rd_at.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int rd_at,
                              output int push_at, output logic [9:0] popped);
        logic [10:0]   bits;
        logic [LW-1:0] lvl0;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        wait_ticks(1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            PS2_DATA = bits[i];
            wait_ticks(HALF);
            @(negedge clk);
            PS2_CLK = 1'b0;
            wait_ticks(HALF);
            @(negedge clk);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = bits[10];
        wait_ticks(HALF);
        @(negedge clk);
        lvl0    = level;
        PS2_CLK = 1'b0;
        push_at = -1;
        popped  = '0;
        for (int c = 1; c <= 3 * HALF * en_div; c++) begin
            @(negedge clk);
            if (push_at < 0 && level != lvl0) push_at = c;
            rd_en = (c == rd_at);
            if (c == rd_at) popped = rd_data;
            if (c == HALF * en_div) PS2_CLK = 1'b1;
        end
        rd_en = 1'b0;
    endtask

    task automatic send_good(input logic [7:0] b, input int rd_at, output int push_at,
                             output logic [9:0] popped);
        bit         do_push;
        logic [9:0] val;
        model_byte(b, do_push, val);
        if (do_push) begin
            if (sb.size() < DEPTH) sb.push_back(val);
            else exp_ovf = 1'b1;
        end
        send_frame(b, 1'b0, rd_at, push_at, popped);
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (4) @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (frame_err_cnt !== '0) begin n_fail++; $display("FAIL reset_ferr: got %0d expected 0", frame_err_cnt); end
        n_checks++; if (timeout_cnt !== '0) begin n_fail++; $display("FAIL reset_tout: got %0d expected 0", timeout_cnt); end
        n_checks++; if (rd_data !== 10'h000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 000", rd_data); end
    endtask

    task automatic test_single();
        int         pa;
        logic [9:0] pv, exp;
        send_good(8'h1C, -1, pa, pv);
        n_checks++; if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level: got %0d expected 1", level); end
        n_checks++; if (rd_data !== 10'h01C) begin n_fail++; $display("FAIL single_head_const: got %h expected 01c", rd_data); end
        exp = sb.pop_front();
        n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL single_head: got %h expected %h", rd_data, exp); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
    endtask

    task automatic test_parity_err();
        int         pa;
        logic [9:0] pv, exp;
        send_frame(8'h1C, 1'b1, -1, pa, pv);
        exp_ferr++;
        model_clear_prefix();
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL parity_nopush: got %0d expected 0", level); end
        n_checks++; if (frame_err_cnt !== CNT_W'(exp_ferr)) begin n_fail++; $display("FAIL parity_ferr: got %0d expected %0d", frame_err_cnt, exp_ferr); end
        send_good(8'h32, -1, pa, pv);
        n_checks++; if (level !== LW'(1)) begin n_fail++; $display("FAIL parity_next_level: got %0d expected 1", level); end
        exp = sb.pop_front();
        n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL parity_next_head: got %h expected %h", rd_data, exp); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic test_prefix();
        int         pa;
        logic [9:0] pv, exp;
        send_good(8'hE0, -1, pa, pv);
        send_good(8'hF0, -1, pa, pv);
        send_good(8'h75, -1, pa, pv);
`ifdef PS2_DECODE_EN
        n_checks++; if (level !== LW'(1)) begin n_fail++; $display("FAIL prefix_count: got %0d expected 1", level); end
`else
        n_checks++; if (level !== LW'(3)) begin n_fail++; $display("FAIL prefix_count: got %0d expected 3", level); end
`endif
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL prefix_entry: got %h expected %h", rd_data, exp); end
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL prefix_drained: got %b expected 1", empty); end
    endtask

    task automatic test_overflow();
        int         pa;
        logic [9:0] pv, exp;
        exp_ovf = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send_good(8'h20 + 8'(i), -1, pa, pv);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
        n_checks++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
        n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", overflow, exp_ovf); end
        n_checks++; if (rd_data !== sb[0]) begin n_fail++; $display("FAIL ovf_head: got %h expected %h", rd_data, sb[0]); end
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL ovf_entry: got %h expected %h", rd_data, exp); end
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b expected 1", empty); end
    endtask

    task automatic test_full_rw();
        int         pa, pa_cal;
        logic [9:0] pv, exp, last;
        bit         dp;
        for (int i = 0; i < DEPTH - 1; i++) send_good(8'h40 + 8'(i), -1, pa, pv);
        send_good(8'h4F, -1, pa_cal, pv);
        n_checks++; if (pa_cal < 2) begin n_fail++; $display("FAIL fullrw_calib: got push at %0d expected a detected push", pa_cal); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullrw_full: got %b expected 1", full); end
        exp = sb.pop_front();
        model_byte(8'h5A, dp, last);
        sb.push_back(last);
        send_frame(8'h5A, 1'b0, pa_cal - 1, pa, pv);
        n_checks++; if (pv !== exp) begin n_fail++; $display("FAIL fullrw_pop: got %h expected %h", pv, exp); end
        n_checks++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fullrw_level: got %0d expected %0d", level, DEPTH); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_ovf: got %b expected 0", overflow); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL fullrw_entry: got %h expected %h", rd_data, exp); end
            rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullrw_drained: got %b expected 1", empty); end
    endtask

    task automatic test_timeout();
        int          pa;
        logic [9:0]  pv, exp;
        logic [10:0] bits;
        bits = {1'b1, ~^8'h55, 8'h55, 1'b0};
        wait_ticks(1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            PS2_DATA = bits[i];
            wait_ticks(HALF); @(negedge clk); PS2_CLK = 1'b0;
            wait_ticks(HALF); @(negedge clk); PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        wait_ticks(TIMEOUT + 16);
        @(negedge clk);
        exp_tout++;
        model_clear_prefix();
        n_checks++; if (timeout_cnt !== CNT_W'(exp_tout)) begin n_fail++; $display("FAIL tout_cnt: got %0d expected %0d", timeout_cnt, exp_tout); end
        n_checks++; if (frame_err_cnt !== CNT_W'(exp_ferr)) begin n_fail++; $display("FAIL tout_ferr: got %0d expected %0d", frame_err_cnt, exp_ferr); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL tout_nopush: got %0d expected 0", level); end
        send_good(8'h4B, -1, pa, pv);
        n_checks++; if (level !== LW'(1)) begin n_fail++; $display("FAIL tout_next_level: got %0d expected 1", level); end
        exp = sb.pop_front();
        n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL tout_next_head: got %h expected %h", rd_data, exp); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;

        // One-tick low pulse with data low: a strobe here would open a frame and skew the next one.
        wait_ticks(1); @(negedge clk);
        PS2_DATA = 1'b0; PS2_CLK = 1'b0;
        wait_ticks(1); @(negedge clk);
        PS2_CLK = 1'b1;
        wait_ticks(10); @(negedge clk);
        PS2_DATA = 1'b1;
        wait_ticks(TIMEOUT + 16);
        @(negedge clk);
        n_checks++; if (timeout_cnt !== CNT_W'(exp_tout)) begin n_fail++; $display("FAIL glitch_tout: got %0d expected %0d", timeout_cnt, exp_tout); end
        send_good(8'h2D, -1, pa, pv);
        n_checks++; if (frame_err_cnt !== CNT_W'(exp_ferr)) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", frame_err_cnt, exp_ferr); end
        exp = sb.pop_front();
        n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL glitch_next_head: got %h expected %h", rd_data, exp); end
        rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b expected 1", empty); end
    endtask

    initial begin
        test_reset();
        en_div = 64;
        test_single();
        en_div = 4;
        test_parity_err();
        test_prefix();
        test_overflow();
        test_full_rw();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
Parametrised PS/2 keyboard receiver that replaces the single-byte DATA/DONE driver.
- Deglitches and synchronises PS2_CLK/PS2_DATA.
- Frames, parity-checks and timeout-checks each 11-bit frame.
- Optionally folds E0/F0 prefixes into flags on the scancode.
- Buffers results in a DEPTH-entry first-word-fall-through FIFO, so the host (keyboard matrix emulation, LED debug top) can drain codes at its own rate without losing keystrokes.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
FILTER_LEN, 4, consecutive identical clk_en samples required before filtered PS2_CLK changes level
TIMEOUT, 2048, clk_en ticks without a filtered falling edge before a partial frame is aborted
CNT_W, 8, width of error counters (saturating)

Ports:
clk  in  1  system clock
nRESET  in  1  synchronous active-low reset
clk_en  in  1  receiver sample enable; all receive-side logic advances only when high
PS2_CLK  in  1  raw PS/2 clock from pad
PS2_DATA  in  1  raw PS/2 data from pad
rd_en  in  1  pop FIFO head (host side; every clk, not gated)
rd_data  out  10  FIFO head {ext, brk, code[7:0]}; valid when !empty
empty  out  1  FIFO empty
full  out  1  FIFO holds DEPTH entries
level  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky; set when a code is dropped because the FIFO is full
ovf_clr  in  1  clears overflow
frame_err_cnt  out  CNT_W  parity or stop-bit failures, saturating
timeout_cnt  out  CNT_W  aborted partial frames, saturating

Behaviour:
Reset state:
- Reset is sampled on clk regardless of clk_en. All state resets on clk with nRESET=0.
- empty=1, full=0, level=0, overflow=0, counters=0, rd_data=0.
- FSM=IDLE, prefix flags cleared, filtered clock=1, synchronisers=1.

Input conditioning:
- Two-flop synchroniser on each PS/2 line, clocked on clk_en ticks.
- Filtered PS2_CLK takes a new level only after FILTER_LEN consecutive equal synchronised samples.
- A falling edge of the filtered clock is the bit strobe. Data is sampled from the synchronised PS2_DATA on the same tick.

Frame FSM (advances on bit strobes):
- IDLE: data=0 -> DATA with bit count 0. Data=1 is a spurious edge: ignore it, stay in IDLE.
- DATA: shift data LSB first; after the 8th bit -> PARITY.
- PARITY: latch the parity bit -> STOP.
- STOP: if stop=1 and byte plus parity has an odd number of ones, the byte is good: deliver it to the decoder one tick later. Otherwise increment frame_err_cnt, drop the byte and clear the prefix flags. Return to IDLE in both cases.

Timeout:
- A watchdog counts clk_en ticks in any state other than IDLE and resets on each strobe.
- Reaching TIMEOUT: go to IDLE, increment timeout_cnt, clear the prefix flags, discard the partial byte.

Decoder (PS2_DECODE_EN defined):
- Byte 0xE0 sets ext. Byte 0xF0 sets brk. Neither prefix is pushed.
- Any other byte pushes {ext, brk, byte} and then clears both flags.
- Example: the sequence E0 F0 75 pushes 0x375.

FIFO:
- Push occurs on the clk after a good code.
- rd_data combinationally reflects the head entry.
- Pop on rd_en when !empty. rd_en while empty is ignored; level is unchanged.
- Push with full && !rd_en: code dropped, overflow set.
- Push and pop in the same clk: both succeed and level is unchanged, including when full.
- Pointers carry an extra wrap bit. full = pointers equal except for the wrap bit.
- ovf_clr clears overflow. If a drop occurs in the same clk, set wins.

Counters:
- Saturate at all-ones and do not wrap.

Optional Feature:
PS2_DECODE_EN:
- Defined: prefix decoding as described above.
- Undefined: every good byte, including E0 and F0, is pushed raw as {2'b00, byte}, and no prefix state exists.
- Framing, FIFO and error behaviour are identical in both cases.

Test Plan:
1. clk_en every 64 clk, send frame for 0x1C with correct odd parity -> one push, rd_data=0x01C, level=1; rd_en pulse -> empty=1.
2. Send 0x1C with parity bit inverted -> no push, frame_err_cnt=1. Then send valid 0x32 -> rd_data=0x032.
3. Send E0, F0, 75 with PS2_DECODE_EN defined -> single entry 0x375. Same bench without the macro -> three entries 0x0E0, 0x0F0, 0x075.
4. DEPTH=8: send 9 codes, no reads -> full=1, level=8, overflow=1, first code still at head. Pulse ovf_clr -> overflow=0.
5. Full FIFO: rd_en in the same clk as the 9th push -> level stays 8, overflow stays 0, newest code at tail.
6. Send start bit plus 3 data bits, then hold PS2_CLK high for TIMEOUT ticks -> timeout_cnt=1, FSM idle. Next full valid frame is received correctly. Inject a 1-tick PS2_CLK glitch (FILTER_LEN=4) -> no strobe, no state change.
